cla5_mp_sequencer: RTL and testbench

CLA5_MP_SEQUENCER -- requirements
Module: cla5_mp_sequencer

---
 rtl/cla5_pkg.sv | 38 +++
 rtl/cla5_slice.sv | 34 +++
 rtl/cla5_mp_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cla5_mp_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla5_pkg.sv
// -----------------------------------------------------------------------------
// cla5_pkg
// Shared definitions for the multi-cycle 5-bit-limb carry-lookahead sequencer.
//   LIMB_W    : width of one limb (5 bits)
//   state_t   : sequencer FSM states IDLE / RUN / DONE
//   la_carry  : carry into bit k+1 of a limb in flattened lookahead form
//               (each carry is a direct sum-of-products of g/p/ci; there is
//               no chaining through the lower carries)
// -----------------------------------------------------------------------------
package cla5_pkg;

  localparam int LIMB_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..1]g[0] | p[k..0]ci
  function automatic logic la_carry(
    input logic [LIMB_W-1:0] g,
    input logic [LIMB_W-1:0] p,
    input logic              ci,
    input int                k
  );
    logic c;
    logic pp;
    c  = 1'b0;
    pp = 1'b1;
    for (int j = k; j >= 0; j--) begin
      c  = c | (pp & g[j]);
      pp = pp & p[j];
    end
    return c | (pp & ci);
  endfunction

endpackage

// File: rtl/cla5_slice.sv
// -----------------------------------------------------------------------------
// cla5_slice
// Combinational 5-bit carry-lookahead adder slice.
//   a5, b5 : limb operands
//   ci     : carry into bit 0
//   s5     : 5-bit slice sum
//   co     : carry out of bit 4
// -----------------------------------------------------------------------------
module cla5_slice
  import cla5_pkg::*;
(
  input  logic [LIMB_W-1:0] a5,
  input  logic [LIMB_W-1:0] b5,
  input  logic              ci,
  output logic [LIMB_W-1:0] s5,
  output logic              co
);

  logic [LIMB_W-1:0] g;
  logic [LIMB_W-1:0] p;
  logic [LIMB_W:0]   c;

  assign g    = a5 & b5;
  assign p    = a5 ^ b5;
  assign c[0] = ci;

  for (genvar gi = 0; gi < LIMB_W; gi++) begin : g_carry
    assign c[gi+1] = la_carry(g, p, ci, gi);
  end

  assign s5 = p ^ c[LIMB_W-1:0];
  assign co = c[LIMB_W];

endmodule

// File: rtl/cla5_mp_sequencer.sv
// -----------------------------------------------------------------------------
// cla5_mp_sequencer
// Multi-cycle W-bit adder (W = 5*LIMBS) built around one shared 5-bit
// carry-lookahead slice. One limb is added per clock, LSB limb first, with
// the carry registered between limbs.
//
// Optional feature macro: CLA5_MP_SEQUENCER_SUB_EN
//   defined   : port sub exists; sub=1 at accept inverts b and forces the
//               carry-in to 1, giving a-b
//   undefined : port sub absent, add only
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand set offered
//   in_ready   : high only in IDLE
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   sub        : subtract request (only with CLA5_MP_SEQUENCER_SUB_EN)
//   out_valid  : result held in DONE until out_ready
//   out_ready  : consumer accepts the result
//   sum        : W-bit result (keeps the previous result while IDLE)
//   cout       : carry out of the top limb
//   ovf        : two's-complement overflow of the W-bit result
//   busy       : high whenever the FSM is not IDLE
//
// Timing: accepting edge -> LIMBS RUN cycles -> DONE. out_valid is seen in
// the (LIMBS+1)-th cycle after the accepting cycle.
// -----------------------------------------------------------------------------
module cla5_mp_sequencer
  import cla5_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMB_W*LIMBS-1:0] a,
  input  logic [LIMB_W*LIMBS-1:0] b,
  input  logic                    cin,
`ifdef CLA5_MP_SEQUENCER_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*LIMBS-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);

  localparam int W     = LIMB_W * LIMBS;
  localparam int IDX_W = $clog2(LIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;       // effective B (already inverted for subtract)
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [LIMB_W-1:0] a_limbs [LIMBS];
  logic [LIMB_W-1:0] b_limbs [LIMBS];
  logic [W-1:0]      sum_d;
  logic [W-1:0]      b_eff_d;
  logic              cin_eff_d;
  logic              ovf_d;
  logic [LIMB_W-1:0] s5;
  logic              co;

  // Limb views of the operands and the per-limb write of the running sum.
  for (genvar gi = 0; gi < LIMBS; gi++) begin : g_limb
    assign a_limbs[gi] = a_q[gi*LIMB_W +: LIMB_W];
    assign b_limbs[gi] = b_q[gi*LIMB_W +: LIMB_W];
    assign sum_d[gi*LIMB_W +: LIMB_W] =
      (idx_q == IDX_W'(gi)) ? s5 : sum_q[gi*LIMB_W +: LIMB_W];
  end

  cla5_slice u_slice (
    .a5 (a_limbs[idx_q]),
    .b5 (b_limbs[idx_q]),
    .ci (carry_q),
    .s5 (s5),
    .co (co)
  );

`ifdef CLA5_MP_SEQUENCER_SUB_EN
  assign b_eff_d   = sub ? ~b : b;
  assign cin_eff_d = sub ? 1'b1 : cin;
`else
  assign b_eff_d   = b;
  assign cin_eff_d = cin;
`endif

  // Only meaningful on the top limb: the slice MSB is then the result MSB.
  assign ovf_d = (a_q[W-1] == b_q[W-1]) && (s5[LIMB_W-1] != a_q[W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b_eff_d;
            carry_q    <= cin_eff_d;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= co;
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            cout_q      <= co;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cla5_mp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla5_mp_sequencer
// Scoreboard bench: the driver pushes the expected result of every accepted
// operation; a monitor compares whenever out_valid is high and drives
// out_ready. Expected values come from plain W+1-bit arithmetic.
// Honours CLA5_MP_SEQUENCER_SUB_EN.
// -----------------------------------------------------------------------------
module tb_cla5_mp_sequencer;

  localparam int LIMBS = 4;
  localparam int W     = 5 * LIMBS;
`ifdef CLA5_MP_SEQUENCER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  cla5_mp_sequencer #(.LIMBS(LIMBS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA5_MP_SEQUENCER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_acc = 0;
  bit           have_acc = 0;
  int           last_hs  = 0;
  bit           have_hs  = 0;
  bit           in_reset = 1;
  int           ready_mode = 2;   // 0 random, 1 hold low 3 DONE cycles, 2 always high
  logic [W-1:0] last_sum = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: effective operands added as W+1-bit integers.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    exp_t         e;
    logic [W-1:0] be;
    logic         ce;
    logic [W:0]   full;
    be     = ts ? ~tb : tb;
    ce     = ts ? 1'b1 : tc;
    full   = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ce};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1]);
    e.acc  = 0;
    return e;
  endfunction

  // Called at a negedge. Holds in_valid until accepted.
  task automatic send_core(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts, input exp_t e);
    int guard;
    bit waited;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    guard = 0; waited = 0;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      waited = 1;
      guard++;
      if (guard > 100) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", guard);
        in_valid = 1'b0;
        return;
      end
    end
    chk("no_result_pending_at_accept", 64'(exp_q.size()), 64'd0);
    if (have_acc)
      chk("throughput_gap_ok", 64'(cyc - last_acc >= LIMBS + 2), 64'd1);
    if (waited && have_hs)
      chk("accept_right_after_handshake", 64'(cyc - last_hs), 64'd1);
    e.acc = cyc;
    exp_q.push_back(e);
    $display("txn accept a=0x%05h b=0x%05h cin=%0d sub=%0d -> exp sum=0x%05h cout=%0d ovf=%0d",
             ta, tb, tc, ts, e.sum, e.cout, e.ovf);
    last_acc = cyc; have_acc = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    sub = SUB_ON ? 1'($urandom) : 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] ta, tb;
    logic tc, ts;
    case ($urandom_range(0, 4))
      0: ta = '1;
      1: ta = {1'b0, {(W-1){1'b1}}};
      2: ta = {1'b1, {(W-1){1'b0}}};
      default: ta = W'($urandom);
    endcase
    tb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom);
    tc = 1'($urandom);
    ts = SUB_ON ? 1'($urandom) : 1'b0;
    send_core(ta, tb, tc, ts, model(ta, tb, tc, ts));
  endtask

  task automatic send_exp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo; e.acc = 0;
    send_core(ta, tb, tc, ts, e);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && in_ready === 1'b1)) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        return;
      end
    end
  endtask

  // Monitor / consumer
  initial begin
    bit prev_ov, prev_hs, hs;
    int done_cnt;
    prev_ov = 0; prev_hs = 0; done_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        chk("busy_is_not_idle", 64'(busy), 64'(!in_ready));
        if (prev_hs) chk("single_cycle_after_handshake", 64'(out_valid), 64'd0);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_out_valid: out_valid=1 with no outstanding operation");
          end else begin
            if (!prev_ov)
              chk("latency", 64'(cyc - exp_q[0].acc), 64'(LIMBS + 1));
            chk("sum", 64'(sum), 64'(exp_q[0].sum));
            chk("cout", 64'(cout), 64'(exp_q[0].cout));
            chk("ovf", 64'(ovf), 64'(exp_q[0].ovf));
            chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
          end
        end else if (in_ready) begin
          chk("idle_sum_hold", 64'(sum), 64'(last_sum));
        end
      end
      hs = 0;
      case (ready_mode)
        0: out_ready = 1'($urandom_range(0, 1));
        1: begin
          if (out_valid) done_cnt++;
          out_ready = out_valid && (done_cnt >= 4);
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready && exp_q.size() > 0) begin
        $display("txn result sum=0x%05h cout=%0d ovf=%0d", sum, cout, ovf);
        last_sum = exp_q[0].sum;
        void'(exp_q.pop_front());
        last_hs = cyc; have_hs = 1; hs = 1; done_cnt = 0;
      end
      prev_hs = hs;
      prev_ov = out_valid;
    end
  end

  // Driver
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    in_reset = 0;

    // Directed scenarios, consumer always ready.
    ready_mode = 2;
    send_exp(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
    send_exp(20'h12345, 20'h0ABCD, 1'b1, 1'b0, 20'h1CF13, 1'b0, 1'b0);
    send_exp(20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1);
`ifdef CLA5_MP_SEQUENCER_SUB_EN
    send_exp(20'h00005, 20'h00007, 1'b1, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
`endif
    wait_idle();

    // Consumer stalls 3 DONE cycles while the next operation is held on in_valid.
    ready_mode = 1;
    send_rand();
    send_rand();
    wait_idle();
    ready_mode = 2;

    // Reset during the third RUN cycle discards the operation.
    send_rand();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; in_reset = 1;
    @(negedge clk);
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_sum", 64'(sum), 64'd0);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    $display("txn reset mid-RUN, operation discarded");
    rst_n = 1'b1; last_sum = '0;
    @(negedge clk);
    in_reset = 0;
    repeat (12) @(negedge clk);

    // Randomized traffic with random consumer backpressure.
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_rand();
    end
    wait_idle();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
